// File: rtl/rf_writeback_queue_pkg.sv
// Package rf_pkg: shared register-file widths and the write-back entry type.
// Imported by the write-back queue, its interface and the bypass matcher.
package rf_pkg;

   localparam int RF_ADDR_W = 6;
   localparam int RF_DATA_W = 32;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/rf_writeback_queue_if.sv
// Producer-side handshake plus register-file write port of the write-back queue.
// master = producer / register-file side, slave = the queue itself.
interface rf_writeback_queue_if
   import rf_pkg::*;
#(
   parameter int N = RF_ADDR_W,
   parameter int M = RF_DATA_W
);

   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_addr;
   logic [M-1:0] in_data;
   logic         wb_stall;
   logic         we3;
   logic [N-1:0] addr3;
   logic [M-1:0] wd3;

   modport master (
      output in_valid, in_addr, in_data, wb_stall,
      input  in_ready, we3, addr3, wd3
   );

   modport slave (
      input  in_valid, in_addr, in_data, wb_stall,
      output in_ready, we3, addr3, wd3
   );

endinterface

// File: rtl/rf_writeback_queue_match.sv
// wbq_match: DEPTH-way bypass address compare with youngest-first selection.
// Only instantiated when RF_WBQ_BYPASS_EN is defined.
module wbq_match
   import rf_pkg::*;
#(
   parameter int N     = RF_ADDR_W,
   parameter int M     = RF_DATA_W,
   parameter int DEPTH = 4
) (
   input  logic [DEPTH-1:0][N-1:0] addrs,
   input  logic [DEPTH-1:0][M-1:0] datas,
   input  logic [DEPTH-1:0]        valid,
   input  logic [$clog2(DEPTH)-1:0] tail_idx,
   input  logic [N-1:0]            lookup_addr,
   output logic                    hit,
   output logic [M-1:0]            data
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] idx;

   // Scan from oldest slot to youngest so the last match written wins.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         idx = tail_idx - AW'(k);
         if (valid[idx] && (addrs[idx] == lookup_addr) && (lookup_addr != '0)) begin
            hit  = 1'b1;
            data = datas[idx];
         end
      end
   end

endmodule

// File: rtl/rf_writeback_queue.sv
// Write-back queue feeding the register file's synchronous write port (we3/addr3/wd3).
// Define RF_WBQ_BYPASS_EN to enable the pending-write bypass lookup.
module rf_writeback_queue
   import rf_pkg::*;
#(
   parameter int N     = RF_ADDR_W,
   parameter int M     = RF_DATA_W,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   rf_writeback_queue_if.slave      bus,
   output logic [$clog2(DEPTH):0]   count,
   input  logic [N-1:0]             lookup_addr,
   output logic                     lookup_hit,
   output logic [M-1:0]             lookup_data
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]               head;
   logic [AW:0]               tail;
   logic [DEPTH-1:0][N-1:0]   addr_q;
   logic [DEPTH-1:0][M-1:0]   data_q;
   logic [DEPTH-1:0]          valid_q;
   logic                      full;
   logic                      empty;
   logic                      push;
   logic                      pop;

   // Extra wrap bit distinguishes full from empty when the slot indices coincide.
   assign empty = (head == tail);
   assign full  = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);
   assign count = tail - head;

   // Writes to register 0 complete the handshake but are never stored.
   assign bus.in_ready = !full;
   assign push         = bus.in_valid && !full && (bus.in_addr != '0);

   assign bus.we3   = !empty && !bus.wb_stall;
   assign pop       = bus.we3;
   assign bus.addr3 = empty ? '0 : addr_q[head[AW-1:0]];
   assign bus.wd3   = empty ? '0 : data_q[head[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         valid_q <= '0;
      end else begin
         if (push) begin
            valid_q[tail[AW-1:0]] <= 1'b1;
            tail                  <= tail + 1'b1;
         end
         if (pop) begin
            valid_q[head[AW-1:0]] <= 1'b0;
            head                  <= head + 1'b1;
         end
      end
   end

   // Payload storage needs no reset; valid bits and pointers gate every use.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail[AW-1:0]] <= bus.in_addr;
         data_q[tail[AW-1:0]] <= bus.in_data;
      end
   end

`ifdef RF_WBQ_BYPASS_EN
   wbq_match #(
      .N     (N),
      .M     (M),
      .DEPTH (DEPTH)
   ) u_match (
      .addrs       (addr_q),
      .datas       (data_q),
      .valid       (valid_q),
      .tail_idx    (tail[AW-1:0]),
      .lookup_addr (lookup_addr),
      .hit         (lookup_hit),
      .data        (lookup_data)
   );
`else
   logic unused_bypass;

   assign unused_bypass = ^{lookup_addr, valid_q};
   assign lookup_hit    = 1'b0;
   assign lookup_data   = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Scoreboard bench for rf_writeback_queue: directed scenarios followed by random traffic.
// Honours RF_WBQ_BYPASS_EN for the expected lookup results.
module tb_rf_writeback_queue;
   import rf_pkg::*;

   localparam int N     = RF_ADDR_W;
   localparam int M     = RF_DATA_W;
   localparam int DEPTH = 4;

   typedef struct {
      logic [N-1:0] addr;
      logic [M-1:0] data;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [$clog2(DEPTH):0] count;
   logic [N-1:0]           lookup_addr;
   logic                   lookup_hit;
   logic [M-1:0]           lookup_data;

   rf_writeback_queue_if #(.N(N), .M(M)) bus();

   rf_writeback_queue #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .count       (count),
      .lookup_addr (lookup_addr),
      .lookup_hit  (lookup_hit),
      .lookup_data (lookup_data)
   );

   always #5 clk = ~clk;

   exp_t         sb[$];
   int           checks = 0;
   int           fails = 0;
   bit           checking = 1'b0;
   bit           model_full = 1'b0;
   bit           exp_hit;
   logic [M-1:0] exp_ld;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: compares the DUT against the pending-write queue mid-cycle and retires issued writes.
   always @(negedge clk) begin
      if (checking) begin
         model_full = (sb.size() >= DEPTH);
         checkOutput("in_ready", 64'(bus.in_ready), 64'(!model_full));
         checkOutput("count", 64'(count), 64'(sb.size()));
         checkOutput("we3", 64'(bus.we3), 64'((sb.size() > 0) && !bus.wb_stall));
         if (sb.size() == 0) begin
            checkOutput("addr3_empty", 64'(bus.addr3), 64'(0));
            checkOutput("wd3_empty", 64'(bus.wd3), 64'(0));
         end else begin
            checkOutput("addr3", 64'(bus.addr3), 64'(sb[0].addr));
            checkOutput("wd3", 64'(bus.wd3), 64'(sb[0].data));
         end
         exp_hit = 1'b0;
         exp_ld  = '0;
`ifdef RF_WBQ_BYPASS_EN
         foreach (sb[i]) begin
            if ((sb[i].addr == lookup_addr) && (lookup_addr != '0)) begin
               exp_hit = 1'b1;
               exp_ld  = sb[i].data;
            end
         end
`endif
         checkOutput("lookup_hit", 64'(lookup_hit), 64'(exp_hit));
         checkOutput("lookup_data", 64'(lookup_data), 64'(exp_ld));
         if (bus.we3 && (sb.size() > 0))
            void'(sb.pop_front());
      end
   end

   // Drives one cycle of inputs, then records the expected effect once the monitor has sampled.
   task automatic applyStimulus(input bit v, input logic [N-1:0] a, input logic [M-1:0] d,
                                input bit stall, input bit r, input logic [N-1:0] la);
      @(posedge clk);
      #1;
      bus.in_valid = v;
      bus.in_addr  = a;
      bus.in_data  = d;
      bus.wb_stall = stall;
      rst          = r;
      lookup_addr  = la;
      #6;
      if (r)
         sb.delete();
      else if (v && !model_full && (a != '0))
         sb.push_back('{a, d});
   endtask

   task automatic idle(input int cycles, input bit stall, input logic [N-1:0] la);
      for (int i = 0; i < cycles; i++)
         applyStimulus(1'b0, '0, '0, stall, 1'b0, la);
   endtask

   logic [N-1:0] ra;
   logic [M-1:0] rd;

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_addr  = '0;
      bus.in_data  = '0;
      bus.wb_stall = 1'b0;
      lookup_addr  = '0;
      @(posedge clk);
      #1;
      checking = 1'b1;
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, '0);

      // Single write, one-cycle latency to the register file
      applyStimulus(1'b1, N'(5), 32'hA5A5_A5A5, 1'b0, 1'b0, N'(5));
      idle(2, 1'b0, N'(5));

      // Fill while stalled, overflow attempt, then drain in order
      for (int i = 1; i <= 5; i++)
         applyStimulus(1'b1, N'(i), M'(32'h100 + i), 1'b1, 1'b0, N'(3));
      idle(1, 1'b1, N'(3));
      idle(6, 1'b0, N'(3));

      // Register-0 writes are accepted but dropped
      applyStimulus(1'b1, '0, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
      idle(2, 1'b0, '0);

      // Steady push+drain stream wrapping the pointers
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b1, N'(10 + i), M'(32'h2000 + i), 1'b0, 1'b0, N'(11));
      idle(2, 1'b0, '0);

      // Two pending writes to the same register; youngest wins the bypass
      applyStimulus(1'b1, N'(7), M'(1), 1'b1, 1'b0, N'(7));
      applyStimulus(1'b1, N'(7), M'(2), 1'b1, 1'b0, N'(7));
      idle(1, 1'b1, N'(7));
      idle(1, 1'b1, '0);
      idle(3, 1'b0, N'(7));

      // Reset with a full handshake pending discards everything
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, N'(20 + i), M'(32'h3000 + i), 1'b1, 1'b0, N'(21));
      applyStimulus(1'b1, N'(9), M'(32'h9999), 1'b0, 1'b1, N'(9));
      idle(2, 1'b0, N'(9));

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'($urandom_range(0, 7));
         rd = M'($urandom);
         applyStimulus($urandom_range(0, 3) != 0, ra, rd, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 199) == 0, N'($urandom_range(0, 7)));
      end

      idle(DEPTH + 3, 1'b0, '0);
      checkOutput("drained", 64'(sb.size()), 64'(0));
      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
